// File: rtl/aoc5_range_parser_pkg.sv
// Shared widths, range-pair type and ASCII constants for the day-5 range parser.
package aoc5_range_parser_pkg;

    localparam int unsigned DATA_WIDTH      = 64;
    localparam int unsigned BANK_ADDR_WIDTH = 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] first;
        logic [DATA_WIDTH-1:0] second;
    } tuple_pair_t;

    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;

    // Highest even bank address; advancing past it wraps to zero.
    localparam logic [BANK_ADDR_WIDTH-1:0] ADDR_LAST_EVEN = {{(BANK_ADDR_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        ST_FIRST,
        ST_SECOND,
        ST_SKIP,
        ST_FLUSH,
        ST_DONE
    } parse_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/aoc5_range_parser_if.sv
// Byte-stream input and range-pair output bundle between host, parser and top.
interface aoc5_range_parser_if;
    import aoc5_range_parser_pkg::*;

    logic [7:0]                 byte_in;
    logic                       byte_valid_in;
    logic                       byte_ready_out;
    logic                       data_valid_out;
    tuple_pair_t                even_data_out;
    tuple_pair_t                odd_data_out;
    logic [BANK_ADDR_WIDTH-1:0] addr_out;
    logic                       stream_done_out;
    logic                       parse_error_out;

    modport master (
        output byte_in,
        output byte_valid_in,
        input  byte_ready_out,
        input  data_valid_out,
        input  even_data_out,
        input  odd_data_out,
        input  addr_out,
        input  stream_done_out,
        input  parse_error_out
    );

    modport slave (
        input  byte_in,
        input  byte_valid_in,
        output byte_ready_out,
        output data_valid_out,
        output even_data_out,
        output odd_data_out,
        output addr_out,
        output stream_done_out,
        output parse_error_out
    );

endinterface

// File: rtl/aoc5_dec_accum.sv
// Decimal accumulator: value = value*10 + digit, truncated, with sticky carry-out flag.
module aoc5_dec_accum
    import aoc5_range_parser_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  digit_en,
    input  logic [3:0]            digit,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  overflow
);

    // Four extra bits hold the full product: 10*(2^W-1)+9 < 2^(W+4).
    logic [DATA_WIDTH+3:0] next_wide;

    always_comb begin
        next_wide = ({4'b0000, value} << 3) + ({4'b0000, value} << 1)
                  + {{DATA_WIDTH{1'b0}}, digit};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            value    <= '0;
            overflow <= 1'b0;
        end else if (digit_en) begin
            value    <= next_wide[DATA_WIDTH-1:0];
            overflow <= overflow | (|next_wide[DATA_WIDTH+3:DATA_WIDTH]);
        end
    end

endmodule

// File: rtl/aoc5_range_parser.sv
// Streaming ASCII parser: "first-second" lines in, even/odd range pairs out to top.
module aoc5_range_parser
    import aoc5_range_parser_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    aoc5_range_parser_if.slave bus
);

    parse_state_t state_q, state_d;

    logic                       alive_q;
    logic                       has_digit_q;
    logic                       odd_slot_q;
    tuple_pair_t                hold_even_q;
    tuple_pair_t                even_q;
    tuple_pair_t                odd_q;
    logic [BANK_ADDR_WIDTH-1:0] addr_q;
    logic [BANK_ADDR_WIDTH-1:0] addr_out_q;
    logic                       valid_q;
    logic                       done_q;
    logic                       error_q;

    logic [DATA_WIDTH-1:0] first_val;
    logic [DATA_WIDTH-1:0] second_val;
    logic                  first_ovf;
    logic                  second_ovf;
    tuple_pair_t           line_pair;

    logic ready;
    logic accept;
    logic is_lf;
    logic is_cr;
    logic is_dash;
    logic is_dig;
    logic wrap_err;

    logic first_en;
    logic second_en;
    logic clear_acc;
    logic set_digit;
    logic err_set;
    logic end_range;
    logic blank_end;

    assign ready     = alive_q && ((state_q == ST_FIRST) || (state_q == ST_SECOND)
                                   || (state_q == ST_SKIP));
    assign accept    = bus.byte_valid_in && ready;
    assign is_lf     = (bus.byte_in == ASCII_LF);
    assign is_cr     = (bus.byte_in == ASCII_CR);
    assign is_dash   = (bus.byte_in == ASCII_DASH);
    assign is_dig    = is_digit(bus.byte_in);
    assign line_pair = '{first: first_val, second: second_val};
    assign wrap_err  = end_range && odd_slot_q && (addr_q == ADDR_LAST_EVEN);

    // ASCII '0'..'9' carry the digit value in the low nibble.
    aoc5_dec_accum u_first_accum (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear_acc),
        .digit_en (first_en),
        .digit    (bus.byte_in[3:0]),
        .value    (first_val),
        .overflow (first_ovf)
    );

    aoc5_dec_accum u_second_accum (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear_acc),
        .digit_en (second_en),
        .digit    (bus.byte_in[3:0]),
        .value    (second_val),
        .overflow (second_ovf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FIRST: begin
                if (err_set) begin
                    state_d = ST_SKIP;
                end else if (blank_end) begin
                    state_d = odd_slot_q ? ST_FLUSH : ST_DONE;
                end else if (accept && is_dash) begin
                    state_d = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (err_set) begin
                    state_d = ST_SKIP;
                end else if (end_range) begin
                    state_d = ST_FIRST;
                end
            end
            ST_SKIP: begin
                if (clear_acc) begin
                    state_d = ST_FIRST;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_FIRST;
        endcase
    end

    always_comb begin
        first_en  = 1'b0;
        second_en = 1'b0;
        clear_acc = 1'b0;
        set_digit = 1'b0;
        err_set   = 1'b0;
        end_range = 1'b0;
        blank_end = 1'b0;
        case (state_q)
            ST_FIRST: begin
                if (accept) begin
                    if (is_dig) begin
                        first_en  = 1'b1;
                        set_digit = 1'b1;
                    end else if (is_lf) begin
                        if (has_digit_q) begin
                            err_set = 1'b1;
                        end else begin
                            blank_end = 1'b1;
                        end
                    end else if (!is_dash && !is_cr) begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_SECOND: begin
                if (accept) begin
                    if (is_dig) begin
                        second_en = 1'b1;
                    end else if (is_lf) begin
                        end_range = 1'b1;
                        clear_acc = 1'b1;
                    end else if (!is_cr) begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                if (accept && is_lf) begin
                    clear_acc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alive_q     <= 1'b0;
            has_digit_q <= 1'b0;
            odd_slot_q  <= 1'b0;
            hold_even_q <= '0;
            even_q      <= '0;
            odd_q       <= '0;
            addr_q      <= '0;
            addr_out_q  <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
            error_q <= error_q | err_set | first_ovf | second_ovf | wrap_err;

            if (set_digit) begin
                has_digit_q <= 1'b1;
            end else if (clear_acc) begin
                has_digit_q <= 1'b0;
            end

            if (end_range) begin
                if (!odd_slot_q) begin
                    hold_even_q <= line_pair;
                    odd_slot_q  <= 1'b1;
                end else begin
                    even_q     <= hold_even_q;
                    odd_q      <= line_pair;
                    addr_out_q <= addr_q;
                    addr_q     <= addr_q + BANK_ADDR_WIDTH'(2);
                    valid_q    <= 1'b1;
                    odd_slot_q <= 1'b0;
                end
            end

            // Lone even entry at end of stream is padded with a copy of itself.
            if (blank_end && odd_slot_q) begin
                even_q     <= hold_even_q;
                odd_q      <= hold_even_q;
                addr_out_q <= addr_q;
                valid_q    <= 1'b1;
                odd_slot_q <= 1'b0;
            end
        end
    end

    assign bus.byte_ready_out  = ready;
    assign bus.data_valid_out  = valid_q;
    assign bus.even_data_out   = even_q;
    assign bus.odd_data_out    = odd_q;
    assign bus.addr_out        = addr_out_q;
    assign bus.stream_done_out = done_q;
    assign bus.parse_error_out = error_q;

endmodule

// File: tb/tb_aoc5_range_parser.sv
// Directed bench for aoc5_range_parser: range pairs, pulse timing, errors, reset.
module tb_aoc5_range_parser;
    import aoc5_range_parser_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    aoc5_range_parser_if bus ();

    aoc5_range_parser dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        tuple_pair_t                ev;
        tuple_pair_t                od;
        logic [BANK_ADDR_WIDTH-1:0] addr;
        int                         stamp;
    } pulse_t;

    pulse_t pq[$];
    int     dq[$];
    int     acc_edge[$];
    int     edge_cnt = 0;
    int     overlap  = 0;
    int     checks   = 0;
    int     errors   = 0;
    string  tc       = "init";

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    always @(negedge clock) begin
        if (bus.data_valid_out) begin
            pulse_t p;
            p.ev    = bus.even_data_out;
            p.od    = bus.odd_data_out;
            p.addr  = bus.addr_out;
            p.stamp = edge_cnt;
            pq.push_back(p);
        end
        if (bus.stream_done_out) dq.push_back(edge_cnt);
        if (bus.data_valid_out && bus.stream_done_out) overlap++;
    end

    function automatic tuple_pair_t tp(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        tuple_pair_t t;
        t.first  = a;
        t.second = b;
        return t;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", tc, tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit   taken = 1'b0;
        logic rdy;
        for (int unsigned g = 0; g < gap; g++) @(negedge clock);
        bus.byte_in       = b;
        bus.byte_valid_in = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            rdy = bus.byte_ready_out;
            @(posedge clock);
            if (rdy) begin
                acc_edge.push_back(edge_cnt);
                taken = 1'b1;
            end
            @(negedge clock);
        end
        bus.byte_valid_in = 1'b0;
        check("byte_accepted", taken, 1);
    endtask

    task automatic send_string(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], gaps ? $urandom_range(0, 3) : 0);
        end
    endtask

    task automatic do_reset();
        bus.byte_valid_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        pq.delete();
        dq.delete();
        acc_edge.delete();
        @(negedge clock);
        check("ready_after_reset", bus.byte_ready_out, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && dq.size() == 0; i++) @(negedge clock);
        repeat (4) @(negedge clock);
        check("done_count", dq.size(), 1);
    endtask

    task automatic check_pulse(input int k, input tuple_pair_t ev, input tuple_pair_t od,
                               input int addr, input int stamp);
        check($sformatf("p%0d_present", k), pq.size() > k, 1);
        if (pq.size() > k) begin
            check($sformatf("p%0d_even", k), pq[k].ev, ev);
            check($sformatf("p%0d_odd", k), pq[k].od, od);
            check($sformatf("p%0d_addr", k), pq[k].addr, addr);
            check($sformatf("p%0d_cycle", k), pq[k].stamp, stamp);
        end
    endtask

    task automatic finish_case(input int n_pulses, input int done_stamp, input bit err);
        check("pulse_count", pq.size(), n_pulses);
        if (dq.size() > 0) check("done_cycle", dq[0], done_stamp);
        check("parse_error", bus.parse_error_out, err);
        check("ready_in_done", bus.byte_ready_out, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_in       = '0;
        bus.byte_valid_in = 1'b0;

        tc = "reset";
        @(negedge clock);
        check("ready", bus.byte_ready_out, 0);
        check("valid", bus.data_valid_out, 0);
        check("done", bus.stream_done_out, 0);
        check("error", bus.parse_error_out, 0);
        check("addr", bus.addr_out, 0);
        check("even", bus.even_data_out, 0);

        tc = "even_count";
        do_reset();
        send_string("3-5\n10-14\n16-20\n12-18\n\n", 1'b0);
        wait_done();
        check_pulse(0, tp(3, 5), tp(10, 14), 0, acc_edge[9] + 1);
        check_pulse(1, tp(16, 20), tp(12, 18), 2, acc_edge[21] + 1);
        finish_case(2, acc_edge[22] + 1, 1'b0);

        tc = "odd_count";
        do_reset();
        send_string("3-5\n10-14\n7-9\n\n", 1'b0);
        wait_done();
        check_pulse(0, tp(3, 5), tp(10, 14), 0, acc_edge[9] + 1);
        check_pulse(1, tp(7, 9), tp(7, 9), 2, acc_edge[14] + 1);
        finish_case(2, acc_edge[14] + 2, 1'b0);

        tc = "crlf_gaps";
        do_reset();
        send_string("3-5\015\n10-14\015\n16-20\015\n12-18\015\n\015\n", 1'b1);
        wait_done();
        check_pulse(0, tp(3, 5), tp(10, 14), 0, acc_edge[11] + 1);
        check_pulse(1, tp(16, 20), tp(12, 18), 2, acc_edge[25] + 1);
        finish_case(2, acc_edge[27] + 1, 1'b0);

        tc = "bad_line";
        do_reset();
        send_string("3-5\n", 1'b0);
        check("error_before_x", bus.parse_error_out, 0);
        send_byte("x", 0);
        check("error_after_x", bus.parse_error_out, 1);
        send_string("-9\n10-14\n20-21\n\n", 1'b0);
        wait_done();
        check_pulse(0, tp(3, 5), tp(10, 14), 0, acc_edge[13] + 1);
        check_pulse(1, tp(20, 21), tp(20, 21), 2, acc_edge[20] + 1);
        finish_case(2, acc_edge[20] + 2, 1'b1);

        // 10^21 - 1 mod 2^64 = 3875820019684212735
        tc = "overflow";
        do_reset();
        send_string("999999999999999999999-1\n2-3\n\n", 1'b0);
        wait_done();
        check_pulse(0, tp(64'd3875820019684212735, 1), tp(2, 3), 0, acc_edge[27] + 1);
        finish_case(1, acc_edge[28] + 1, 1'b1);

        tc = "mid_reset";
        do_reset();
        send_string("3-5\n1", 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("no_pulse", pq.size(), 0);
        check("no_done", dq.size(), 0);
        check("ready_in_reset", bus.byte_ready_out, 0);
        reset = 1'b0;
        pq.delete();
        dq.delete();
        acc_edge.delete();
        @(negedge clock);
        send_string("8-9\n6-7\n\n", 1'b0);
        wait_done();
        check_pulse(0, tp(8, 9), tp(6, 7), 0, acc_edge[7] + 1);
        finish_case(1, acc_edge[8] + 1, 1'b0);

        tc = "global";
        check("valid_done_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
